muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO result registers; the parametrised, multi-mode successor of the single-cycle combinational ALU.
- Executes MULT, MULTU, DIV and DIVU over WIDTH-bit operands using a shift-add multiplier and a restoring divider, one bit per cycle.
- Sits beside the main ALU in the execute stage. Control starts an operation with a start/busy/done handshake and reads HI/LO afterwards. HI/LO are also writable directly (MTHI/MTLO).

Parameters:
- WIDTH, 32, operand and HI/LO width in bits; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  input  WIDTH  multiplicand / dividend; sampled on the accepting edge.
- b  input  WIDTH  multiplier / divisor; sampled on the accepting edge.
- hi_we  input  1  write wdata into HI (MTHI); honoured only in IDLE.
- lo_we  input  1  write wdata into LO (MTLO); honoured only in IDLE.
- wdata  input  WIDTH  data for hi_we/lo_we.
- busy  output  1  high while an operation is in progress (state != IDLE).
- done  output  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- div_by_zero  output  1  pulses with done when DIV/DIVU had b == 0; low otherwise.
- hi  output  WIDTH  HI register: product upper half / remainder.
- lo  output  WIDTH  LO register: product lower half / quotient.

Behaviour:
- Reset (async, any state): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; any in-flight operation is discarded.
- States and transitions:
  - IDLE -> RUN on a rising edge with start=1.
  - RUN -> FIN after exactly WIDTH iteration edges.
  - FIN -> IDLE on the next edge.
- Accepting edge (IDLE, start=1): latch op.
  - For signed ops, latch |a| and |b| and record the result signs: product sign = a^b sign; quotient sign = a^b sign; remainder sign = dividend sign.
  - Clear the iteration counter.
- RUN:
  - Multiply: one shift-add step per edge on a 2*WIDTH accumulator.
  - Divide: one restoring subtract/shift step per edge.
- FIN edge:
  - Apply two's-complement sign correction.
  - Write hi/lo; done<=1; div_by_zero<=(divide && b==0).
- Latency: with start accepted at edge E, done and the new hi/lo are visible after edge E+WIDTH+1, for exactly one cycle.
  - busy is high after edges E..E+WIDTH and low in the done cycle.
  - A new start is accepted in the done cycle.
- Arithmetic rules:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed overflow (most-negative / -1): lo = most-negative value, hi = 0; no flag.
  - Divide by zero, both DIV and DIVU: lo = all ones, hi = a as latched (unmodified signed value); div_by_zero=1.
- Handshake and write boundary cases:
  - start while busy: ignored; no effect on the running operation.
  - hi_we/lo_we while busy: ignored.
  - hi_we/lo_we in IDLE without start: the register updates on that edge.
  - hi_we and lo_we together in IDLE: both registers update.
  - start together with hi_we/lo_we in IDLE: start is accepted and the writes are discarded.
- hi/lo hold their values between operations; they change only on FIN, an honoured write, or reset.
- Operands a, b and op may change freely after the accepting edge.

Test Plan:
- Timing: WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 33 edges after the accepting edge; busy high for 33 cycles, low in the done cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 for one cycle only.
- Handshake:
  - start=1 with new operands every cycle while busy -> the first result is unaffected.
  - hi_we=1 wdata=0x1234 while busy -> ignored.
  - hi_we=1 wdata=0x1234 in IDLE -> hi=0x1234 on the next edge, lo unchanged.
- Reset mid-operation: assert reset 10 cycles into a DIV -> immediately busy=0, hi=lo=0, no done pulse. After release, MULTU 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Control-side handshake and result bus of the iterative multiply/divide unit.
// The master drives requests and HI/LO writes; the unit (slave) returns status and results.
interface muldiv_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, sign-corrected on the final cycle.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input logic          clk,
   input logic          reset,
   muldiv_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               is_div, neg_res, neg_rem, b_zero;
   logic [WIDTH-1:0]   opnd, a_raw;
   logic [2*WIDTH-1:0] acc;
   logic               load, step, finish, wr_hi, wr_lo, last;
   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic               busy_r, done_r, dbz_r;
   logic [WIDTH-1:0]   hi_r, lo_r;

   // op[0] clear selects the signed variants
   assign neg_a = ~bus.op[0] & bus.a[WIDTH-1];
   assign neg_b = ~bus.op[0] & bus.b[WIDTH-1];
   assign mag_a = neg_a ? -bus.a : bus.a;
   assign mag_b = neg_b ? -bus.b : bus.b;
   assign last  = (cnt == CNT_W'(WIDTH - 1));

   // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, dividend/quotient}
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
   assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
   assign prod_fix = neg_res ? -acc : acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A start in IDLE takes priority over MTHI/MTLO on the same edge
   always_comb begin
      load   = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      wr_hi  = 1'b0;
      wr_lo  = 1'b0;
      case (state)
         IDLE: begin
            load  = bus.start;
            wr_hi = bus.hi_we & ~bus.start;
            wr_lo = bus.lo_we & ~bus.start;
         end
         RUN:     step   = 1'b1;
         FIN:     finish = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         b_zero  <= 1'b0;
         opnd    <= '0;
         a_raw   <= '0;
         acc     <= '0;
      end else if (load) begin
         cnt     <= '0;
         is_div  <= bus.op[1];
         neg_res <= neg_a ^ neg_b;
         neg_rem <= neg_a;
         b_zero  <= (bus.b == '0);
         opnd    <= bus.op[1] ? mag_b : mag_a;
         acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
         a_raw   <= bus.a;
      end else if (step) begin
         cnt <= cnt + CNT_W'(1);
         if (is_div)
            acc <= div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc <= {mul_sum, acc[WIDTH-1:1]};
      end
   end

   // Final sign correction; divide-by-zero returns all-ones quotient and the raw dividend
   always_comb begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
      if (is_div) begin
         if (b_zero) begin
            res_hi = a_raw;
            res_lo = '1;
         end else begin
            res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            res_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
      end else begin
         busy_r <= (state_nxt != IDLE);
         done_r <= finish;
         dbz_r  <= finish & is_div & b_zero;
         if (finish) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
         end else begin
            if (wr_hi) hi_r <= bus.wdata;
            if (wr_lo) lo_r <= bus.wdata;
         end
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, randomized ops against a 64-bit
// arithmetic model, and hand-written handshake, write-port and reset sequences.
module tb_muldiv_unit;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned LAT   = WIDTH + 1;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dbz;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference arithmetic on 64-bit integers
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic z);
      longint          sa, sb, q, r;
      longint unsigned p;
      z = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin
            q = sa * sb;
            {h, l} = q;
         end
         2'b01: begin
            p = {32'd0, a} * {32'd0, b};
            {h, l} = p;
         end
         default: begin
            if (b == 32'd0) begin
               h = a;
               l = 32'hFFFF_FFFF;
               z = 1'b1;
            end else if (op == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               l = q[31:0];
               h = r[31:0];
            end else begin
               l = a / b;
               h = a % b;
            end
         end
      endcase
   endfunction

   // mode 0: quiet; 1: start held with fresh operands while busy; 2: MTHI/MTLO held while busy
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         input int mode, input string nm);
      int   n;
      logic seen, busy_ok;
      @(negedge clk);
      bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = (mode == 1);
      bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
      if (mode == 2) begin
         bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h1234;
      end
      busy_ok = bus.busy;
      n = 0;
      seen = 1'b0;
      while (!seen && n < LAT + 8) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.done) begin
            seen = 1'b1;
            bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
         end else begin
            if (!bus.busy) busy_ok = 1'b0;
            if (mode == 1) begin
               bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
            end
         end
      end
      check($sformatf("%s/latency", nm), 64'(n), 64'(LAT));
      check($sformatf("%s/busy", nm), {62'd0, busy_ok, bus.busy}, 64'b10);
      check($sformatf("%s/hi", nm), 64'(bus.hi), 64'(eh));
      check($sformatf("%s/lo", nm), 64'(bus.lo), 64'(el));
      check($sformatf("%s/dbz", nm), 64'(bus.div_by_zero), 64'(ed));
      @(posedge clk);
      #1;
      check($sformatf("%s/pulse", nm), {62'd0, bus.done, bus.div_by_zero}, 64'd0);
      check($sformatf("%s/hold", nm), {bus.hi, bus.lo}, {eh, el});
   endtask

   vec_t vecs[9];

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b, eh, el;
      logic        ez, got_done;
      int          n;

      checks = 0;
      errors = 0;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
      reset = 1'b1;
      #12;
      check("reset/state", {59'd0, bus.busy, bus.done, bus.div_by_zero, 2'b00}, 64'd0);
      check("reset/hilo", {bus.hi, bus.lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[4] = '{2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
      vecs[5] = '{2'b10, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1};
      vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[7] = '{2'b11, 32'd7,         32'd9,         32'h0000_0007, 32'h0000_0000, 1'b0};
      vecs[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};

      for (int i = 0; i < 9; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                vecs[i].exp_dbz, 0, $sformatf("vec%0d", i));

      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         model(op, a, b, eh, el, ez);
         run_op(op, a, b, eh, el, ez, 0, $sformatf("rnd%0d", i));
      end

      run_op(2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 1, "start_busy");
      run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 2, "write_busy");

      // MTHI alone, then MTHI+MTLO together, in IDLE
      @(negedge clk);
      bus.hi_we = 1'b1; bus.wdata = 32'h1234;
      @(posedge clk);
      #1;
      bus.hi_we = 1'b0;
      check("mthi/hilo", {bus.hi, bus.lo}, {32'h1234, 32'd42});
      @(negedge clk);
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hABCD;
      @(posedge clk);
      #1;
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      check("mthilo/hilo", {bus.hi, bus.lo}, {32'hABCD, 32'hABCD});

      // start wins over simultaneous writes
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5555;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      check("start_wr/hilo", {bus.hi, bus.lo}, {32'hABCD, 32'hABCD});
      check("start_wr/busy", 64'(bus.busy), 64'd1);
      n = 0;
      while (!bus.done && n < LAT + 8) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("start_wr/latency", 64'(n), 64'(LAT));
      check("start_wr/result", {bus.hi, bus.lo}, {32'd0, 32'd6});

      // reset ten cycles into a divide
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset/flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
      check("midreset/hilo", {bus.hi, bus.lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      got_done = 1'b0;
      repeat (LAT + 4) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) got_done = 1'b1;
      end
      check("midreset/no_done", 64'(got_done), 64'd0);
      run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 0, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
